// File: rtl/instr_fetch.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// instr_fetch
// Program-sequencing stage of the PLC core. Drives the instruction ROM address
// from the PC, registers the returned word into the instruction register (IR),
// and resolves JMP, JMA, CLL, RET and RST locally. CLL/RET use a small
// hardware return stack. Control-flow changes insert bubbles into the IR.
//
// Opcode encoding (ROM word [23:16]):
//   8'h00 NOP   8'h20 JMP   8'h21 JMA   8'h22 CLL   8'h23 RET   8'h2F RST
//   Any other opcode is passed to the decode/execute stage unchanged.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst_n      in   synchronous active-low reset
//   rom_addr   out  PC driven to the ROM (equals the PC register)
//   rom_data   in   ROM word at rom_addr, valid in the same cycle
//   stall      in   execute stage busy: freeze all state
//   acu_nz     in   accumulator != 0, sampled in the JMA wait cycle
//   ir_opcode  out  registered opcode
//   ir_operand out  registered operand
//   ir_valid   out  1 = IR holds an instruction, 0 = bubble
//   ir_pc      out  address the IR word was fetched from
//   sp         out  return-stack occupancy, 0..STACK_DEPTH
//   fault      out  sticky stack overflow/underflow flag; core is halted
// ---------------------------------------------------------------------------
module instr_fetch #(
   parameter int ADDR_BITS   = 8,
   parameter int WORD_WIDTH  = 24,
   parameter int STACK_DEPTH = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   output logic [ADDR_BITS-1:0]           rom_addr,
   input  logic [WORD_WIDTH-1:0]          rom_data,
   input  logic                           stall,
   input  logic                           acu_nz,
   output logic [7:0]                     ir_opcode,
   output logic [15:0]                    ir_operand,
   output logic                           ir_valid,
   output logic [ADDR_BITS-1:0]           ir_pc,
   output logic [$clog2(STACK_DEPTH):0]   sp,
   output logic                           fault
);

   localparam int SP_BITS  = $clog2(STACK_DEPTH) + 1;
   localparam int IDX_BITS = SP_BITS - 1;

   localparam logic [7:0] OP_NOP = 8'h00;
   localparam logic [7:0] OP_JMP = 8'h20;
   localparam logic [7:0] OP_JMA = 8'h21;
   localparam logic [7:0] OP_CLL = 8'h22;
   localparam logic [7:0] OP_RET = 8'h23;
   localparam logic [7:0] OP_RST = 8'h2F;

   localparam logic [ADDR_BITS-1:0] PC_ONE  = ADDR_BITS'(1);
   localparam logic [SP_BITS-1:0]   SP_ONE  = SP_BITS'(1);
   localparam logic [SP_BITS-1:0]   SP_FULL = SP_BITS'(STACK_DEPTH);
   localparam logic [IDX_BITS-1:0]  IDX_ONE = IDX_BITS'(1);

   typedef enum logic [1:0] {
      ST_FETCH    = 2'd0,
      ST_JMA_WAIT = 2'd1,
      ST_HALT     = 2'd2
   } state_t;

   state_t                 state_q;
   logic [ADDR_BITS-1:0]   pc_q;
   logic [7:0]             ir_opcode_q;
   logic [15:0]            ir_operand_q;
   logic                   ir_valid_q;
   logic [ADDR_BITS-1:0]   ir_pc_q;
   logic [SP_BITS-1:0]     sp_q;
   logic                   fault_q;

   // Return stack; not cleared by reset or RST.
   logic [ADDR_BITS-1:0]   stack_mem [STACK_DEPTH];

   logic [7:0]             word_opcode;
   logic [15:0]            word_operand;
   logic [ADDR_BITS-1:0]   target;
   logic [ADDR_BITS-1:0]   pc_plus1;
   logic                   stack_full;
   logic                   stack_empty;
   logic                   push_en;
   logic [IDX_BITS-1:0]    pop_idx;
   logic [ADDR_BITS-1:0]   stack_top;

   assign word_opcode  = rom_data[WORD_WIDTH-1 -: 8];
   assign word_operand = rom_data[15:0];
   // Upper operand bits beyond the PC width are ignored for branch targets.
   assign target       = rom_data[ADDR_BITS-1:0];
   assign pc_plus1     = pc_q + PC_ONE;
   assign stack_full   = (sp_q == SP_FULL);
   assign stack_empty  = (sp_q == '0);

   // When sp == STACK_DEPTH the low index bits wrap to 0, so subtracting one
   // still lands on the top entry (STACK_DEPTH-1).
   assign pop_idx   = sp_q[IDX_BITS-1:0] - IDX_ONE;
   assign stack_top = stack_mem[pop_idx];

   assign push_en = rst_n && !stall && (state_q == ST_FETCH) &&
                    (word_opcode == OP_CLL) && !stack_full;

   always_ff @(posedge clk) begin
      if (push_en) begin
         stack_mem[sp_q[IDX_BITS-1:0]] <= pc_plus1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_FETCH;
         pc_q         <= '0;
         ir_opcode_q  <= OP_NOP;
         ir_operand_q <= '0;
         ir_valid_q   <= 1'b0;
         ir_pc_q      <= '0;
         sp_q         <= '0;
         fault_q      <= 1'b0;
      end else if (!stall) begin
         // Default is a bubble; only a plain instruction in FETCH loads the IR.
         ir_opcode_q  <= OP_NOP;
         ir_operand_q <= '0;
         ir_valid_q   <= 1'b0;
         case (state_q)
            ST_FETCH: begin
               case (word_opcode)
                  OP_JMP: begin
                     pc_q <= target;
                  end
                  OP_JMA: begin
                     // PC holds so rom_data still presents the JMA word
                     // (and its target) during the wait cycle.
                     state_q <= ST_JMA_WAIT;
                  end
                  OP_CLL: begin
                     if (stack_full) begin
                        fault_q <= 1'b1;
                        state_q <= ST_HALT;
                     end else begin
                        sp_q <= sp_q + SP_ONE;
                        pc_q <= target;
                     end
                  end
                  OP_RET: begin
                     if (stack_empty) begin
                        fault_q <= 1'b1;
                        state_q <= ST_HALT;
                     end else begin
                        sp_q <= sp_q - SP_ONE;
                        pc_q <= stack_top;
                     end
                  end
                  OP_RST: begin
                     pc_q <= '0;
                     sp_q <= '0;
                  end
                  default: begin
                     ir_opcode_q  <= word_opcode;
                     ir_operand_q <= word_operand;
                     ir_valid_q   <= 1'b1;
                     ir_pc_q      <= pc_q;
                     pc_q         <= pc_plus1;
                  end
               endcase
            end
            ST_JMA_WAIT: begin
               pc_q    <= acu_nz ? target : pc_plus1;
               state_q <= ST_FETCH;
            end
            ST_HALT: begin
               // Frozen until reset; IR stays a bubble.
               state_q <= ST_HALT;
            end
            default: begin
               state_q <= ST_FETCH;
            end
         endcase
      end
   end

   assign rom_addr   = pc_q;
   assign ir_opcode  = ir_opcode_q;
   assign ir_operand = ir_operand_q;
   assign ir_valid   = ir_valid_q;
   assign ir_pc      = ir_pc_q;
   assign sp         = sp_q;
   assign fault      = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Directed testbench for instr_fetch. A behavioural ROM array is read
// combinationally at rom_addr. Outputs are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

   localparam logic [7:0] NOP = 8'h00;
   localparam logic [7:0] LDI = 8'h01;
   localparam logic [7:0] ST  = 8'h02;
   localparam logic [7:0] JMP = 8'h20;
   localparam logic [7:0] JMA = 8'h21;
   localparam logic [7:0] CLL = 8'h22;
   localparam logic [7:0] RET = 8'h23;
   localparam logic [7:0] RST = 8'h2F;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rom_addr;
   logic [23:0] rom_data;
   logic        stall = 1'b0;
   logic        acu_nz = 1'b0;
   logic [7:0]  ir_opcode;
   logic [15:0] ir_operand;
   logic        ir_valid;
   logic [7:0]  ir_pc;
   logic [3:0]  sp;
   logic        fault;

   logic [23:0] rom [256];

   int n_checks = 0;
   int n_fail   = 0;

   assign rom_data = rom[rom_addr];

   always #5 clk = ~clk;

   instr_fetch #(.ADDR_BITS(8), .WORD_WIDTH(24), .STACK_DEPTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .stall      (stall),
      .acu_nz     (acu_nz),
      .ir_opcode  (ir_opcode),
      .ir_operand (ir_operand),
      .ir_valid   (ir_valid),
      .ir_pc      (ir_pc),
      .sp         (sp),
      .fault      (fault)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = 24'h0;
   endtask

   // Two reset cycles, then release; the next edge is cycle 1.
   task automatic do_reset();
      rst_n = 1'b0; stall = 1'b0; acu_nz = 1'b0;
      step(); step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      clear_rom();
      rom[0] = {LDI, 16'h1234};
      rst_n = 1'b0; stall = 1'b1; acu_nz = 1'b1;
      step(); step();
      n_checks++; if (rom_addr !== 8'd0) begin n_fail++; $display("FAIL reset_pc: got %0d want 0", rom_addr); end
      n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", ir_valid); end
      n_checks++; if (ir_opcode !== NOP) begin n_fail++; $display("FAIL reset_opcode: got %0h want %0h", ir_opcode, NOP); end
      n_checks++; if (ir_operand !== 16'd0) begin n_fail++; $display("FAIL reset_operand: got %0h want 0", ir_operand); end
      n_checks++; if (ir_pc !== 8'd0) begin n_fail++; $display("FAIL reset_ir_pc: got %0d want 0", ir_pc); end
      n_checks++; if (sp !== 4'd0) begin n_fail++; $display("FAIL reset_sp: got %0d want 0", sp); end
      n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %0b want 0", fault); end
      stall = 1'b0; acu_nz = 1'b0;
   endtask

   task automatic test_sequential();
      logic [7:0]  exp_op [3];
      logic [15:0] exp_operand [3];
      clear_rom();
      rom[0] = {NOP, 16'h0000};
      rom[1] = {LDI, 16'h0005};
      rom[2] = {ST,  16'h0001};
      exp_op[0] = NOP; exp_op[1] = LDI; exp_op[2] = ST;
      exp_operand[0] = 16'h0; exp_operand[1] = 16'h5; exp_operand[2] = 16'h1;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++; if (ir_valid !== 1'b1 || ir_opcode !== exp_op[i] || ir_operand !== exp_operand[i] || ir_pc !== 8'(i))
            begin n_fail++; $display("FAIL seq_ir%0d: got v=%0b op=%0h opd=%0h pc=%0d want v=1 op=%0h opd=%0h pc=%0d", i, ir_valid, ir_opcode, ir_operand, ir_pc, exp_op[i], exp_operand[i], i); end
      end
      n_checks++; if (rom_addr !== 8'd3) begin n_fail++; $display("FAIL seq_pc: got %0d want 3", rom_addr); end
   endtask

   task automatic test_call_return();
      clear_rom();
      rom[1]  = {CLL, 16'd20};
      rom[2]  = {ST,  16'd1};
      rom[20] = {LDI, 16'd5};
      rom[21] = {RET, 16'd0};
      do_reset();
      step(); // NOP at 0
      step(); // CLL
      n_checks++; if (rom_addr !== 8'd20 || sp !== 4'd1 || ir_valid !== 1'b0)
         begin n_fail++; $display("FAIL cll_jump: got pc=%0d sp=%0d v=%0b want pc=20 sp=1 v=0", rom_addr, sp, ir_valid); end
      step();
      n_checks++; if (ir_valid !== 1'b1 || ir_opcode !== LDI || ir_pc !== 8'd20)
         begin n_fail++; $display("FAIL cll_body: got v=%0b op=%0h pc=%0d want v=1 op=%0h pc=20", ir_valid, ir_opcode, ir_pc, LDI); end
      step(); // RET
      n_checks++; if (rom_addr !== 8'd2 || sp !== 4'd0 || ir_valid !== 1'b0 || ir_pc !== 8'd20)
         begin n_fail++; $display("FAIL ret_jump: got pc=%0d sp=%0d v=%0b ir_pc=%0d want pc=2 sp=0 v=0 ir_pc=20", rom_addr, sp, ir_valid, ir_pc); end
      step();
      n_checks++; if (ir_valid !== 1'b1 || ir_opcode !== ST || ir_pc !== 8'd2)
         begin n_fail++; $display("FAIL ret_after: got v=%0b op=%0h pc=%0d want v=1 op=%0h pc=2", ir_valid, ir_opcode, ir_pc, ST); end
   endtask

   task automatic test_jma();
      logic [7:0] exp_pc [2];
      exp_pc[0] = 8'd8; exp_pc[1] = 8'd15;
      clear_rom();
      rom[0]  = {JMP, 16'd14};
      rom[14] = {JMA, 16'd8};
      for (int k = 0; k < 2; k++) begin
         do_reset();
         step(); // JMP 14
         step(); // JMA: pc holds
         n_checks++; if (rom_addr !== 8'd14 || ir_valid !== 1'b0)
            begin n_fail++; $display("FAIL jma_hold%0d: got pc=%0d v=%0b want pc=14 v=0", k, rom_addr, ir_valid); end
         acu_nz = (k == 0);
         step(); // wait cycle
         acu_nz = 1'b0;
         n_checks++; if (rom_addr !== exp_pc[k] || ir_valid !== 1'b0)
            begin n_fail++; $display("FAIL jma_branch%0d: got pc=%0d v=%0b want pc=%0d v=0", k, rom_addr, ir_valid, exp_pc[k]); end
         step();
         n_checks++; if (ir_valid !== 1'b1 || ir_pc !== exp_pc[k])
            begin n_fail++; $display("FAIL jma_after%0d: got v=%0b ir_pc=%0d want v=1 ir_pc=%0d", k, ir_valid, ir_pc, exp_pc[k]); end
      end
   endtask

   task automatic test_stack_fault();
      clear_rom();
      rom[0] = {CLL, 16'd0};
      do_reset();
      for (int i = 0; i < 8; i++) step();
      n_checks++; if (sp !== 4'd8 || fault !== 1'b0 || rom_addr !== 8'd0)
         begin n_fail++; $display("FAIL ovf_fill: got sp=%0d fault=%0b pc=%0d want sp=8 fault=0 pc=0", sp, fault, rom_addr); end
      step(); // 9th CLL
      n_checks++; if (fault !== 1'b1 || ir_valid !== 1'b0 || sp !== 4'd8)
         begin n_fail++; $display("FAIL ovf_fault: got fault=%0b v=%0b sp=%0d want fault=1 v=0 sp=8", fault, ir_valid, sp); end
      rom[0] = {LDI, 16'd3};
      step(); step();
      n_checks++; if (fault !== 1'b1 || ir_valid !== 1'b0 || rom_addr !== 8'd0)
         begin n_fail++; $display("FAIL ovf_halt: got fault=%0b v=%0b pc=%0d want fault=1 v=0 pc=0", fault, ir_valid, rom_addr); end
      do_reset();
      n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %0b want 0", fault); end
      rom[0] = {RET, 16'd0};
      step();
      n_checks++; if (fault !== 1'b1 || ir_valid !== 1'b0 || sp !== 4'd0)
         begin n_fail++; $display("FAIL udf_fault: got fault=%0b v=%0b sp=%0d want fault=1 v=0 sp=0", fault, ir_valid, sp); end
      rom[0] = {RST, 16'd0};
      step();
      n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL udf_sticky: got %0b want 1", fault); end
      do_reset();
      n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL udf_clear: got %0b want 0", fault); end
   endtask

   task automatic test_stall();
      clear_rom();
      rom[0] = {LDI, 16'd5};
      rom[1] = {ST,  16'd1};
      do_reset();
      step();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++; if (rom_addr !== 8'd1 || ir_valid !== 1'b1 || ir_opcode !== LDI || ir_pc !== 8'd0)
            begin n_fail++; $display("FAIL stall_fetch%0d: got pc=%0d v=%0b op=%0h ir_pc=%0d want pc=1 v=1 op=%0h ir_pc=0", i, rom_addr, ir_valid, ir_opcode, ir_pc, LDI); end
      end
      stall = 1'b0;
      step();
      n_checks++; if (ir_opcode !== ST || ir_pc !== 8'd1 || rom_addr !== 8'd2)
         begin n_fail++; $display("FAIL stall_release: got op=%0h ir_pc=%0d pc=%0d want op=%0h ir_pc=1 pc=2", ir_opcode, ir_pc, rom_addr, ST); end

      clear_rom();
      rom[0]  = {JMP, 16'd14};
      rom[14] = {JMA, 16'd8};
      do_reset();
      step(); step();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         acu_nz = (i % 2 == 0);
         step();
         n_checks++; if (rom_addr !== 8'd14 || ir_valid !== 1'b0)
            begin n_fail++; $display("FAIL stall_jma%0d: got pc=%0d v=%0b want pc=14 v=0", i, rom_addr, ir_valid); end
      end
      stall = 1'b0; acu_nz = 1'b0;
      step();
      n_checks++; if (rom_addr !== 8'd15) begin n_fail++; $display("FAIL stall_jma_release: got pc=%0d want 15", rom_addr); end
   endtask

   task automatic test_boundaries();
      // Reset in JMA_WAIT with three frames on the stack.
      clear_rom();
      rom[0] = {CLL, 16'd1};
      rom[1] = {CLL, 16'd2};
      rom[2] = {CLL, 16'd3};
      rom[3] = {JMA, 16'd8};
      do_reset();
      step(); step(); step(); step();
      n_checks++; if (sp !== 4'd3 || rom_addr !== 8'd3)
         begin n_fail++; $display("FAIL wait_setup: got sp=%0d pc=%0d want sp=3 pc=3", sp, rom_addr); end
      rst_n = 1'b0; acu_nz = 1'b1;
      step();
      rst_n = 1'b1;
      n_checks++; if (sp !== 4'd0 || rom_addr !== 8'd0)
         begin n_fail++; $display("FAIL wait_reset: got sp=%0d pc=%0d want sp=0 pc=0", sp, rom_addr); end
      rom[0] = {LDI, 16'd5};
      step(); // FETCH: executes LDI; a stale JMA_WAIT would branch to 5
      acu_nz = 1'b0;
      n_checks++; if (ir_valid !== 1'b1 || rom_addr !== 8'd1)
         begin n_fail++; $display("FAIL wait_state: got v=%0b pc=%0d want v=1 pc=1", ir_valid, rom_addr); end

      // RST opcode
      clear_rom();
      rom[0]  = {CLL, 16'd40};
      rom[40] = {RST, 16'd0};
      do_reset();
      step();
      step();
      n_checks++; if (rom_addr !== 8'd0 || sp !== 4'd0 || ir_valid !== 1'b0 || fault !== 1'b0)
         begin n_fail++; $display("FAIL rst_op: got pc=%0d sp=%0d v=%0b fault=%0b want pc=0 sp=0 v=0 fault=0", rom_addr, sp, ir_valid, fault); end

      // JMP at the last address
      clear_rom();
      rom[0]   = {JMP, 16'd255};
      rom[255] = {JMP, 16'h0109};
      do_reset();
      step(); step();
      n_checks++; if (rom_addr !== 8'd9) begin n_fail++; $display("FAIL jmp_255: got pc=%0d want 9", rom_addr); end

      // Plain instruction at the last address wraps the PC
      rom[255] = {LDI, 16'd7};
      do_reset();
      step(); step();
      n_checks++; if (rom_addr !== 8'd0 || ir_pc !== 8'd255 || ir_opcode !== LDI)
         begin n_fail++; $display("FAIL wrap_255: got pc=%0d ir_pc=%0d op=%0h want pc=0 ir_pc=255 op=%0h", rom_addr, ir_pc, ir_opcode, LDI); end

      // CLL at the last address pushes 0
      rom[255] = {CLL, 16'd50};
      rom[50]  = {RET, 16'd0};
      rom[0]   = {JMP, 16'd255};
      do_reset();
      step(); step();
      n_checks++; if (rom_addr !== 8'd50 || sp !== 4'd1) begin n_fail++; $display("FAIL cll_255: got pc=%0d sp=%0d want pc=50 sp=1", rom_addr, sp); end
      step();
      n_checks++; if (rom_addr !== 8'd0 || sp !== 4'd0) begin n_fail++; $display("FAIL ret_255: got pc=%0d sp=%0d want pc=0 sp=0", rom_addr, sp); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_call_return();
      test_jma();
      test_stack_fault();
      test_stall();
      test_boundaries();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
